spgd_meas_sequencer: RTL
========================

Name: spgd_meas_sequencer

Overview:
Controller that sequences the ADC acquisition datapath for one SPGD gradient estimate per iteration. For each iteration it does the following, in order:
- applies a positive perturbation, waits for settling, then runs one averaged ADC measurement;
- applies a negative perturbation, waits for settling, then runs a second measurement;
- reports J_PLUS, J_MINUS and their signed difference.

It drives the acquisition block's enable, consumes its DONE/REG_WRITE/16Q48 result, and pulses the perturbation driver.

Parameters:
FLOAT_WIDTH, 64, width of the 16Q48 measurement and result words
CNT_WIDTH, 16, width of the iteration and settle counters
TMO_WIDTH, 24, width of the measurement timeout counter

Ports:
ADC_CLK  input  1  sole clock
RST  input  1  asynchronous active-high reset
START  input  1  level, sampled in IDLE; begins a run
ABORT  input  1  level; forces return to IDLE from any state
ITER_COUNT  input  CNT_WIDTH  iterations per run; 0 = run until ABORT
SETTLE_CYCLES  input  CNT_WIDTH  wait after each PERT_APPLY before measuring
TIMEOUT_CYCLES  input  TMO_WIDTH  max cycles in MEASURE; 0 = no timeout
ADC_DONE  input  1  average-complete flag from acquisition block (status only)
ADC_REG_WRITE  input  1  result-valid strobe from acquisition block
ADC_VALUE  input  FLOAT_WIDTH  16Q48 measurement, valid when ADC_REG_WRITE=1
ADC_ENABLE  output  1  enable to acquisition block
PERT_APPLY  output  1  one-cycle strobe to perturbation driver
PERT_SIGN  output  1  0 = +delta, 1 = -delta; stable from PERT_APPLY until next PERT_APPLY
J_PLUS  output  FLOAT_WIDTH  last + measurement
J_MINUS  output  FLOAT_WIDTH  last - measurement
J_DIFF  output  FLOAT_WIDTH  J_PLUS - J_MINUS, two's complement
RESULT_VALID  output  1  one-cycle strobe, J_* coherent
ITER_INDEX  output  CNT_WIDTH  index of iteration being or just reported
BUSY  output  1  high in every state except IDLE and ERROR
TIMEOUT_ERR  output  1  sticky timeout flag

Behaviour:
- Reset (async, RST=1): state IDLE.
  - All outputs 0: ADC_ENABLE, PERT_APPLY, PERT_SIGN, J_PLUS, J_MINUS, J_DIFF, RESULT_VALID, ITER_INDEX, BUSY, TIMEOUT_ERR.
  - Latched config cleared.
- Config latch: ITER_COUNT, SETTLE_CYCLES and TIMEOUT_CYCLES are registered on the START-accept cycle. Later input changes have no effect until the next run.
- States: IDLE, APPLY, SETTLE, MEASURE, REPORT, ERROR.
- IDLE:
  - START=1 latches config, clears TIMEOUT_ERR, ITER_INDEX=0, PERT_SIGN=0 and goes to APPLY.
- APPLY (1 cycle):
  - PERT_APPLY=1, ADC_ENABLE=0, settle counter loaded.
  - Next state is SETTLE if SETTLE_CYCLES>0, else MEASURE.
- SETTLE:
  - Counts exactly SETTLE_CYCLES cycles, then MEASURE.
  - APPLY-to-first-ADC_ENABLE-high latency = SETTLE_CYCLES+1 cycles.
- MEASURE:
  - ADC_ENABLE=1 held; timeout counter increments each cycle.
  - On ADC_REG_WRITE=1, ADC_VALUE is captured into J_PLUS (sign 0) or J_MINUS (sign 1) on that edge, and ADC_ENABLE drops the next cycle.
  - If sign 0: PERT_SIGN=1, go to APPLY.
  - If sign 1: go to REPORT.
  - ADC_ENABLE is low at least 1 cycle between measurements (APPLY guarantees this), so the acquisition FSM re-arms.
- Timeout:
  - Triggers in MEASURE when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no ADC_REG_WRITE.
  - Result: TIMEOUT_ERR=1, ADC_ENABLE=0, state ERROR.
  - If ADC_REG_WRITE arrives on the same cycle the count reaches TIMEOUT_CYCLES, the capture wins and there is no error.
- REPORT (1 cycle):
  - J_DIFF = J_PLUS - J_MINUS, modulo 2^FLOAT_WIDTH, with no saturation.
  - J_DIFF is registered so that it is valid on the same cycle RESULT_VALID=1.
  - Then:
    - if ITER_COUNT!=0 and ITER_INDEX==ITER_COUNT-1: go to IDLE, with ITER_INDEX holding its final value;
    - otherwise: ITER_INDEX+1, PERT_SIGN=0, go to APPLY.
  - ITER_INDEX wraps at 2^CNT_WIDTH when ITER_COUNT=0.
- ERROR:
  - Outputs held, BUSY=0.
  - Exits to IDLE only on START=1 (which re-arms and restarts, i.e. acts as IDLE's START) or on ABORT.
- ABORT:
  - From any state, the next cycle is IDLE with ADC_ENABLE=0, PERT_APPLY=0, PERT_SIGN=0.
  - J_* and ITER_INDEX hold; no RESULT_VALID.
  - ABORT has priority over START and ADC_REG_WRITE on the same cycle.
- ADC_REG_WRITE outside MEASURE is ignored.
- ADC_DONE is not used for sequencing.
- START held high after run completion immediately begins a new run. IDLE lasts 1 cycle.
- Reset mid-operation: immediate async return to reset values.

Test Plan:
- Nominal run:
  - Stimulus: ITER_COUNT=2, SETTLE_CYCLES=3, TIMEOUT_CYCLES=0; the ADC model asserts REG_WRITE 5 cycles after ENABLE rises, with values 0x0001_8000_0000_0000 (+) then 0x0001_0000_0000_0000 (-).
  - Required: 4 PERT_APPLY pulses with signs 0,1,0,1; each ENABLE rise 4 cycles after its APPLY.
  - Required: 2 RESULT_VALID pulses with J_DIFF=0x0000_8000_0000_0000 and ITER_INDEX=0 then 1; BUSY=0 afterwards.
- Negative difference:
  - Stimulus: J+=0x0001_0000_0000_0000, J-=0x0002_0000_0000_0000.
  - Required: J_DIFF=0xFFFF_0000_0000_0000.
- Zero settle:
  - Stimulus: SETTLE_CYCLES=0.
  - Required: ADC_ENABLE rises exactly 1 cycle after PERT_APPLY.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=10 and REG_WRITE is never asserted.
  - Required: after 10 MEASURE cycles, TIMEOUT_ERR=1, ADC_ENABLE=0, BUSY=0.
  - Then START=1 clears TIMEOUT_ERR and restarts with PERT_SIGN=0. Also check REG_WRITE on exactly cycle 10 yields capture and no error.
- Abort and continuous mode:
  - Stimulus: ITER_COUNT=0; ABORT is asserted during SETTLE of iteration 3.
  - Required: IDLE next cycle, ENABLE=0, ITER_INDEX=3, no further RESULT_VALID.
  - Also: ABORT coinciding with REG_WRITE gives no capture.
- Async reset:
  - Stimulus: RST pulsed mid-MEASURE, between clock edges.
  - Required: all outputs 0 immediately, without waiting for a clock edge; a new START runs normally.

Source files
------------

// File: rtl/spgd_meas_sequencer.sv
// spgd_meas_sequencer
//
// Sequences one SPGD gradient estimate per iteration. Each iteration has two
// halves. The first applies +delta, waits for settling and runs an averaged
// ADC measurement. The second does the same with -delta. The iteration then
// reports J_PLUS, J_MINUS and the two's-complement difference J_DIFF.
//
// Ports
//   ADC_CLK, RST        sole clock, asynchronous active-high reset
//   START, ABORT        run control (ABORT wins over everything)
//   ITER_COUNT          iterations per run, 0 = run until ABORT
//   SETTLE_CYCLES       wait after each PERT_APPLY before measuring
//   TIMEOUT_CYCLES      max cycles per measurement, 0 = no timeout
//   ADC_DONE            acquisition status (not used for sequencing)
//   ADC_REG_WRITE       result-valid strobe, ADC_VALUE captured with it
//   ADC_VALUE           16Q48 measurement
//   ADC_ENABLE          enable to the acquisition block
//   PERT_APPLY          one-cycle strobe to the perturbation driver
//   PERT_SIGN           0 = +delta, 1 = -delta
//   J_PLUS/J_MINUS      last +/- measurement
//   J_DIFF              J_PLUS - J_MINUS, valid with RESULT_VALID
//   RESULT_VALID        one-cycle result strobe
//   ITER_INDEX          iteration being or just reported
//   BUSY                high outside IDLE and ERROR
//   TIMEOUT_ERR         sticky measurement timeout flag
module spgd_meas_sequencer #(
  parameter int FLOAT_WIDTH = 64,
  parameter int CNT_WIDTH   = 16,
  parameter int TMO_WIDTH   = 24
) (
  input  logic                          ADC_CLK,
  input  logic                          RST,
  input  logic                          START,
  input  logic                          ABORT,
  input  logic        [CNT_WIDTH-1:0]   ITER_COUNT,
  input  logic        [CNT_WIDTH-1:0]   SETTLE_CYCLES,
  input  logic        [TMO_WIDTH-1:0]   TIMEOUT_CYCLES,
  input  logic                          ADC_DONE,
  input  logic                          ADC_REG_WRITE,
  input  logic signed [FLOAT_WIDTH-1:0] ADC_VALUE,
  output logic                          ADC_ENABLE,
  output logic                          PERT_APPLY,
  output logic                          PERT_SIGN,
  output logic signed [FLOAT_WIDTH-1:0] J_PLUS,
  output logic signed [FLOAT_WIDTH-1:0] J_MINUS,
  output logic signed [FLOAT_WIDTH-1:0] J_DIFF,
  output logic                          RESULT_VALID,
  output logic        [CNT_WIDTH-1:0]   ITER_INDEX,
  output logic                          BUSY,
  output logic                          TIMEOUT_ERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_MEASURE,
    ST_REPORT,
    ST_ERROR
  } state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0] iter_cfg;
  logic [CNT_WIDTH-1:0] settle_cfg;
  logic [TMO_WIDTH-1:0] tmo_cfg;
  logic [CNT_WIDTH-1:0] settle_cnt;
  logic [TMO_WIDTH-1:0] tmo_cnt;

  logic start_acc;
  logic cap_plus;
  logic cap_minus;
  logic tmo_hit;
  logic advance_iter;

  // Completion status from the acquisition block is deliberately ignored;
  // ADC_REG_WRITE alone marks a usable result.
  logic unused_adc_done;
  assign unused_adc_done = ADC_DONE;

  // Gradient difference wraps modulo 2^FLOAT_WIDTH; saturating would bias
  // the estimate, so overflow is left to the caller's scaling.
  function automatic logic signed [FLOAT_WIDTH-1:0] wrap_sub(
    input logic signed [FLOAT_WIDTH-1:0] a,
    input logic signed [FLOAT_WIDTH-1:0] b
  );
    wrap_sub = a - b;
  endfunction

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_acc    = 1'b0;
    cap_plus     = 1'b0;
    cap_minus    = 1'b0;
    tmo_hit      = 1'b0;
    advance_iter = 1'b0;
    if (ABORT) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        // ERROR re-arms exactly like IDLE does.
        ST_IDLE, ST_ERROR: begin
          if (START) begin
            start_acc = 1'b1;
            state_nxt = ST_APPLY;
          end
        end
        ST_APPLY: begin
          state_nxt = (settle_cfg != '0) ? ST_SETTLE : ST_MEASURE;
        end
        ST_SETTLE: begin
          if (settle_cnt == settle_cfg - CNT_WIDTH'(1)) state_nxt = ST_MEASURE;
        end
        ST_MEASURE: begin
          // A capture on the final allowed cycle beats the timeout.
          if (ADC_REG_WRITE) begin
            if (!PERT_SIGN) begin
              cap_plus  = 1'b1;
              state_nxt = ST_APPLY;
            end else begin
              cap_minus = 1'b1;
              state_nxt = ST_REPORT;
            end
          end else if ((tmo_cfg != '0) && (tmo_cnt == tmo_cfg - TMO_WIDTH'(1))) begin
            tmo_hit   = 1'b1;
            state_nxt = ST_ERROR;
          end
        end
        ST_REPORT: begin
          if ((iter_cfg != '0) && (ITER_INDEX == iter_cfg - CNT_WIDTH'(1))) begin
            state_nxt = ST_IDLE;
          end else begin
            advance_iter = 1'b1;
            state_nxt    = ST_APPLY;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      iter_cfg    <= '0;
      settle_cfg  <= '0;
      tmo_cfg     <= '0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      PERT_SIGN   <= 1'b0;
      J_PLUS      <= '0;
      J_MINUS     <= '0;
      J_DIFF      <= '0;
      ITER_INDEX  <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      if (start_acc) begin
        iter_cfg    <= ITER_COUNT;
        settle_cfg  <= SETTLE_CYCLES;
        tmo_cfg     <= TIMEOUT_CYCLES;
        TIMEOUT_ERR <= 1'b0;
        ITER_INDEX  <= '0;
        PERT_SIGN   <= 1'b0;
      end

      if (state == ST_APPLY)       settle_cnt <= '0;
      else if (state == ST_SETTLE) settle_cnt <= settle_cnt + CNT_WIDTH'(1);

      if (state == ST_MEASURE) tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
      else                     tmo_cnt <= '0;

      if (cap_plus) begin
        J_PLUS    <= ADC_VALUE;
        PERT_SIGN <= 1'b1;
      end

      // J_DIFF is formed from the incoming minus sample so it is already
      // registered when REPORT raises RESULT_VALID.
      if (cap_minus) begin
        J_MINUS <= ADC_VALUE;
        J_DIFF  <= wrap_sub(J_PLUS, ADC_VALUE);
      end

      if (tmo_hit) TIMEOUT_ERR <= 1'b1;

      if (advance_iter) begin
        ITER_INDEX <= ITER_INDEX + CNT_WIDTH'(1);
        PERT_SIGN  <= 1'b0;
      end

      if (ABORT) PERT_SIGN <= 1'b0;
    end
  end

  assign PERT_APPLY   = (state == ST_APPLY);
  assign ADC_ENABLE   = (state == ST_MEASURE);
  assign RESULT_VALID = (state == ST_REPORT);
  assign BUSY         = (state != ST_IDLE) && (state != ST_ERROR);

endmodule
